// File: rtl/enc_top.sv
// Dual-channel incremental-encoder measurement block.
// Each channel measures A-edge period (SEL=0) or A-edge position (SEL=1),
// referenced to its Z index pulse, with saturation and a sticky overflow flag.
module enc_top #(
    parameter int unsigned CNT_W       = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_ARM,
    input  logic             I_SEL,
    input  logic             I_A0,
    input  logic             I_A1,
    input  logic             I_Z0,
    input  logic             I_Z1,
    output logic             O_A0,
    output logic             O_A1,
    output logic             O_Z0,
    output logic             O_Z1,
    output logic             O_SEL,
    output logic [CNT_W-1:0] O_CNT_A0,
    output logic [CNT_W-1:0] O_CNT_A1,
    output logic             O_OVERFLOW_0,
    output logic             O_OVERFLOW_1,
    output logic             O_READY_0,
    output logic             O_READY_1
);

    localparam int unsigned NCH   = 2;
    localparam int unsigned NSIG  = 6;
    localparam int unsigned P_ARM = 0;
    localparam int unsigned P_SEL = 1;
    localparam int unsigned P_A0  = 2;
    localparam int unsigned P_A1  = 3;
    localparam int unsigned P_Z0  = 4;
    localparam int unsigned P_Z1  = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_Z,
        S_ACTIVE
    } state_e;

    logic [NSIG-1:0]                  pins;
    logic [SYNC_STAGES-1:0][NSIG-1:0] sync_q;
    logic [NSIG-1:0]                  sync_last;
    logic [NCH-1:0]                   a_s;
    logic [NCH-1:0]                   z_s;
    logic [NCH-1:0]                   a_prev_q;
    logic [NCH-1:0]                   z_prev_q;
    logic [NCH-1:0]                   a_edge;
    logic [NCH-1:0]                   z_edge;
    logic                             arm_s;
    logic                             sel_s;

    state_e                           state_q   [NCH];
    logic [CNT_W-1:0]                 cnt_q     [NCH];
    logic [CNT_W-1:0]                 cnt_out_q [NCH];
    logic [CNT_W-1:0]                 cnt_inc_d [NCH];
    logic [NCH-1:0]                   cnt_sat_d;
    logic [NCH-1:0]                   ovf_q;
    logic [NCH-1:0]                   rdy_q;

    assign pins      = {I_Z1, I_Z0, I_A1, I_A0, I_SEL, I_ARM};
    assign sync_last = sync_q[SYNC_STAGES-1];
    assign arm_s     = sync_last[P_ARM];
    assign sel_s     = sync_last[P_SEL];
    assign a_s       = {sync_last[P_A1], sync_last[P_A0]};
    assign z_s       = {sync_last[P_Z1], sync_last[P_Z0]};
    assign a_edge    = a_s & ~a_prev_q;
    assign z_edge    = z_s & ~z_prev_q;

    // Synchroniser chain for every pin plus the previous-value flops for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q   <= '0;
            a_prev_q <= '0;
            z_prev_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pins};
            a_prev_q <= a_s;
            z_prev_q <= z_s;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        // Saturating increment: the counter sticks at all ones instead of wrapping
        always_comb begin
            cnt_sat_d[ch] = (cnt_q[ch] == {CNT_W{1'b1}});
            cnt_inc_d[ch] = cnt_sat_d[ch] ? cnt_q[ch] : cnt_q[ch] + CNT_W'(1);
        end

        // Per-channel measurement state machine; A latch is taken before a coincident Z clear
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q[ch]   <= S_IDLE;
                cnt_q[ch]     <= '0;
                cnt_out_q[ch] <= '0;
                ovf_q[ch]     <= 1'b0;
                rdy_q[ch]     <= 1'b0;
            end else begin
                rdy_q[ch] <= 1'b0;
                if (!arm_s) begin
                    state_q[ch] <= S_IDLE;
                    cnt_q[ch]   <= '0;
                    ovf_q[ch]   <= 1'b0;
                end else begin
                    case (state_q[ch])
                        S_IDLE: begin
                            cnt_q[ch]   <= '0;
                            state_q[ch] <= S_WAIT_Z;
                        end
                        S_WAIT_Z: begin
                            if (z_edge[ch]) begin
                                cnt_q[ch]   <= '0;
                                state_q[ch] <= S_ACTIVE;
                            end
                        end
                        S_ACTIVE: begin
                            if (a_edge[ch]) begin
                                cnt_out_q[ch] <= cnt_inc_d[ch];
                                rdy_q[ch]     <= 1'b1;
                                if (cnt_sat_d[ch]) begin
                                    ovf_q[ch] <= 1'b1;
                                end
                            end
                            if (z_edge[ch]) begin
                                cnt_q[ch] <= '0;
                            end else if (a_edge[ch]) begin
                                cnt_q[ch] <= sel_s ? cnt_inc_d[ch] : '0;
                            end else if (!sel_s) begin
                                cnt_q[ch] <= cnt_inc_d[ch];
                                if (cnt_sat_d[ch]) begin
                                    ovf_q[ch] <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_q[ch] <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign O_A0         = sync_last[P_A0];
    assign O_A1         = sync_last[P_A1];
    assign O_Z0         = sync_last[P_Z0];
    assign O_Z1         = sync_last[P_Z1];
    assign O_SEL        = sel_s;
    assign O_CNT_A0     = cnt_out_q[0];
    assign O_CNT_A1     = cnt_out_q[1];
    assign O_OVERFLOW_0 = ovf_q[0];
    assign O_OVERFLOW_1 = ovf_q[1];
    assign O_READY_0    = rdy_q[0];
    assign O_READY_1    = rdy_q[1];

endmodule

// File: tb/tb_enc_top.sv
// Directed bench for enc_top: period/position measurement, disarm, index
// re-zero, coincident A/Z edges and counter saturation on a narrow instance.
`timescale 1ns/1ps
module tb_enc_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, sel, a0, a1, z0, z1;
    logic        o_a0, o_a1, o_z0, o_z1, o_sel;
    logic [63:0] cnt0, cnt1;
    logic        ovf0, ovf1, rdy0, rdy1;

    // narrow instance used only to reach saturation in a few cycles
    logic        w_arm, w_sel, w_a0, w_a1, w_z0, w_z1;
    logic        w_oa0, w_oa1, w_oz0, w_oz1, w_osel;
    logic [3:0]  w_cnt0, w_cnt1;
    logic        w_ovf0, w_ovf1, w_rdy0, w_rdy1;

    int          total = 0;
    int          bad   = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] exp_q[$];

    logic        a0_d1 = 1'b0, a0_d2 = 1'b0, a1_d1 = 1'b0, a1_d2 = 1'b0;
    logic        rdy0_d = 1'b0, rdy1_d = 1'b0;

    always #4 clk = ~clk;

    enc_top #(.CNT_W(64), .SYNC_STAGES(2)) u_dut (
        .CLK(clk), .RST(rst), .I_ARM(arm), .I_SEL(sel),
        .I_A0(a0), .I_A1(a1), .I_Z0(z0), .I_Z1(z1),
        .O_A0(o_a0), .O_A1(o_a1), .O_Z0(o_z0), .O_Z1(o_z1), .O_SEL(o_sel),
        .O_CNT_A0(cnt0), .O_CNT_A1(cnt1),
        .O_OVERFLOW_0(ovf0), .O_OVERFLOW_1(ovf1),
        .O_READY_0(rdy0), .O_READY_1(rdy1)
    );

    enc_top #(.CNT_W(4), .SYNC_STAGES(2)) u_ovf (
        .CLK(clk), .RST(rst), .I_ARM(w_arm), .I_SEL(w_sel),
        .I_A0(w_a0), .I_A1(w_a1), .I_Z0(w_z0), .I_Z1(w_z1),
        .O_A0(w_oa0), .O_A1(w_oa1), .O_Z0(w_oz0), .O_Z1(w_oz1), .O_SEL(w_osel),
        .O_CNT_A0(w_cnt0), .O_CNT_A1(w_cnt1),
        .O_OVERFLOW_0(w_ovf0), .O_OVERFLOW_1(w_ovf1),
        .O_READY_0(w_rdy0), .O_READY_1(w_rdy1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_a(input int ch, input logic v);
        if (ch == 0) a0 = v; else a1 = v;
    endtask

    task automatic set_z(input int ch, input logic v);
        if (ch == 0) z0 = v; else z1 = v;
    endtask

    // n A pulses of hi/lo cycles; one-cycle Z pulse at cycle zoff of edge zedge (0 = none)
    task automatic gen(input int ch, input int n, input int hi, input int lo,
                       input int zedge, input int zoff);
        for (int e = 1; e <= n; e++) begin
            for (int i = 0; i < hi + lo; i++) begin
                set_a(ch, i < hi);
                set_z(ch, (e == zedge) && (i == zoff));
                @(negedge clk);
            end
        end
        set_a(ch, 1'b0);
        set_z(ch, 1'b0);
    endtask

    // Compare the strobed values of one channel against exp_q, then clear both
    task automatic expect_q(input string tag, input int ch);
        logic [63:0] got[$];
        got = (ch == 0) ? q0 : q1;
        chk($sformatf("%s_count", tag), 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_val%0d", tag, i), (i < got.size()) ? got[i] : 64'hX, exp_q[i]);
        end
        if (ch == 0) q0.delete(); else q1.delete();
        exp_q.delete();
    endtask

    task automatic rearm(input logic new_sel);
        arm = 1'b0;
        step(5);
        sel = new_sel;
        step(5);
        arm = 1'b1;
        step(5);
    endtask

    // Strobe monitor: records values, checks latency vs O_A rise and one-cycle width
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rdy0 === 1'b1) begin
                q0.push_back(cnt0);
                chk("rdy0_after_oa0_rise", 64'({a0_d2, a0_d1}), 64'd1);
                chk("rdy0_one_cycle", 64'(rdy0_d), 64'd0);
            end
            if (rdy1 === 1'b1) begin
                q1.push_back(cnt1);
                chk("rdy1_after_oa1_rise", 64'({a1_d2, a1_d1}), 64'd1);
                chk("rdy1_one_cycle", 64'(rdy1_d), 64'd0);
            end
        end
        a0_d2  = a0_d1;
        a0_d1  = o_a0;
        a1_d2  = a1_d1;
        a1_d1  = o_a1;
        rdy0_d = (rdy0 === 1'b1);
        rdy1_d = (rdy1 === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {arm, sel, a0, a1, z0, z1} = '0;
        {w_arm, w_sel, w_a0, w_a1, w_z0, w_z1} = '0;
        step(3);
        rst = 1'b0;
        step(2);

        // reset / idle state
        chk("rst_cnt0", cnt0, 64'd0);
        chk("rst_cnt1", cnt1, 64'd0);
        chk("rst_rdy", 64'({rdy1, rdy0}), 64'd0);
        chk("rst_ovf", 64'({ovf1, ovf0}), 64'd0);
        chk("rst_w_cnt0", 64'(w_cnt0), 64'd0);

        // two-stage pin-to-output latency
        a0 = 1'b1;
        z1 = 1'b1;
        step(1);
        chk("oa0_lat1", 64'(o_a0), 64'd0);
        chk("oz1_lat1", 64'(o_z1), 64'd0);
        step(1);
        chk("oa0_lat2", 64'(o_a0), 64'd1);
        chk("oz1_lat2", 64'(o_z1), 64'd1);
        a0 = 1'b0;
        z1 = 1'b0;
        step(4);
        chk("idle_no_strobe", 64'(q0.size() + q1.size()), 64'd0);

        // period mode, channel 0: Z one cycle after 3rd A edge
        rearm(1'b0);
        gen(0, 6, 500, 500, 3, 1);
        step(5);
        exp_q = '{64'd999, 64'd1000, 64'd1000};
        expect_q("period0", 0);
        exp_q.delete();
        expect_q("period0_ch1_quiet", 1);

        // mode change while disarmed; O_SEL latency; O_CNT holds
        arm = 1'b0;
        step(5);
        chk("disarm_hold_cnt0", cnt0, 64'd1000);
        sel = 1'b1;
        step(1);
        chk("osel_lat1", 64'(o_sel), 64'd0);
        step(1);
        chk("osel_lat2", 64'(o_sel), 64'd1);
        step(3);
        arm = 1'b1;
        step(5);

        // position mode, channel 1: count 1,2,3; Z coincident with A re-zeroes after latch
        gen(1, 6, 500, 500, 3, 1);
        gen(1, 3, 500, 500, 2, 0);
        step(5);
        exp_q = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd1};
        expect_q("position1", 1);

        // disarm mid-run, then re-arm needing a fresh Z
        gen(1, 2, 20, 20, 0, 0);
        arm = 1'b0;
        step(5);
        chk("disarm_hold_cnt1", cnt1, 64'd3);
        gen(1, 2, 20, 20, 0, 0);
        arm = 1'b1;
        step(5);
        gen(1, 2, 20, 20, 0, 0);
        chk("waitz_hold_cnt1", cnt1, 64'd3);
        gen(1, 3, 20, 20, 1, 3);
        step(5);
        exp_q = '{64'd2, 64'd3, 64'd1, 64'd2};
        expect_q("disarm1", 1);
        exp_q.delete();
        expect_q("pos_ch0_quiet", 0);

        // period mode, both channels, different periods, coincident A/Z
        rearm(1'b0);
        fork
            gen(0, 2, 500, 500, 1, 1);
            gen(1, 2, 350, 350, 1, 1);
        join
        fork
            gen(0, 3, 500, 500, 2, 0);
            gen(1, 3, 350, 350, 2, 0);
        join
        step(5);
        exp_q = '{64'd999, 64'd1000, 64'd1000, 64'd1000};
        expect_q("dual0", 0);
        exp_q = '{64'd699, 64'd1300, 64'd700, 64'd700};
        expect_q("dual1", 1);
        chk("dual_no_ovf", 64'({ovf1, ovf0}), 64'd0);

        // saturation on the 4-bit instance
        w_arm = 1'b1;
        step(5);
        w_z0 = 1'b1;
        step(1);
        w_z0 = 1'b0;
        step(17);
        chk("ovf_before_sat", 64'(w_ovf0), 64'd0);
        step(1);
        chk("ovf_set", 64'(w_ovf0), 64'd1);
        w_a0 = 1'b1;
        step(1);
        w_a0 = 1'b0;
        step(2);
        chk("ovf_latch_rdy", 64'(w_rdy0), 64'd1);
        chk("ovf_latch_ones", 64'(w_cnt0), 64'd15);
        step(5);
        chk("ovf_sticky", 64'(w_ovf0), 64'd1);
        chk("ovf_ch1_clear", 64'(w_ovf1), 64'd0);
        w_arm = 1'b0;
        step(4);
        chk("ovf_cleared_disarm", 64'(w_ovf0), 64'd0);
        chk("ovf_cnt_hold", 64'(w_cnt0), 64'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
